// File: rtl/exception_redirect_ctrl_pkg.sv
// Shared CP0 definitions for the exception redirect controller: FSM state
// encoding, default exception vector and the outstanding-counter update rule.
package exception_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [31:0] EXC_VECTOR_DEFAULT      = 32'hBFC00380;
  localparam int          MAX_OUTSTANDING_DEFAULT = 4;
  localparam int          CNT_W_DEFAULT           = 3;

  // Next value of an outstanding-transaction counter. A request at the
  // maximum is a protocol error and the count holds; a response at zero with
  // no request is ignored; a simultaneous request and response cancel out.
  function automatic int next_count(input int cnt, input logic inc,
                                    input logic dec, input int max);
    if (inc && !dec) return (cnt >= max) ? cnt : cnt + 1;
    if (dec && !inc) return (cnt == 0) ? cnt : cnt - 1;
    return cnt;
  endfunction

endpackage

// File: rtl/exception_redirect_ctrl_if.sv
// Handshake/bus bundle between MEM/CP0, the IF stage and the exception
// redirect controller. timeout_err exists only when EXC_REDIRECT_TIMEOUT_EN
// is defined.
interface exception_redirect_ctrl_if #(parameter int CNT_W = 3);

  logic             exc_valid;
  logic             eret_valid;
  logic [31:0]      epc;
  logic             inst_req_fire;
  logic             inst_resp_fire;
  logic             data_req_fire;
  logic             data_resp_fire;
  logic             if_ready;
  logic             flush;
  logic             fetch_hold;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             inst_resp_discard;
  logic             busy;
  logic [CNT_W-1:0] inst_outstanding;
`ifdef EXC_REDIRECT_TIMEOUT_EN
  logic             timeout_err;
`endif

  // Controller side: owns the flush/hold/redirect outputs.
  modport master (
`ifdef EXC_REDIRECT_TIMEOUT_EN
    output timeout_err,
`endif
    input  exc_valid, eret_valid, epc,
    input  inst_req_fire, inst_resp_fire, data_req_fire, data_resp_fire,
    input  if_ready,
    output flush, fetch_hold, redirect_valid, redirect_pc,
    output inst_resp_discard, busy, inst_outstanding
  );

  // Pipeline side: reports commits and bus fires, consumes the redirect.
  modport slave (
`ifdef EXC_REDIRECT_TIMEOUT_EN
    input  timeout_err,
`endif
    output exc_valid, eret_valid, epc,
    output inst_req_fire, inst_resp_fire, data_req_fire, data_resp_fire,
    output if_ready,
    input  flush, fetch_hold, redirect_valid, redirect_pc,
    input  inst_resp_discard, busy, inst_outstanding
  );

endinterface

// File: rtl/exception_redirect_ctrl_outstanding_counter.sv
// Saturating up/down counter tracking in-flight requests on one SRAM-like bus.
module outstanding_counter
  import exception_redirect_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int MAX   = MAX_OUTSTANDING_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  // Track accepted requests minus returned responses, clamped to [0, MAX].
  always_ff @(posedge clk) begin
    if (!resetn) count <= '0;
    else         count <= CNT_W'(next_count(int'(count), inc, dec, MAX));
  end

endmodule

// File: rtl/exception_redirect_ctrl.sv
// Exception/ERET redirect controller: flushes the pipeline, holds fetch,
// drains outstanding bus traffic, then offers IF the redirect PC.
// Optional drain watchdog enabled by defining EXC_REDIRECT_TIMEOUT_EN.
module exception_redirect_ctrl
  import exception_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR      = EXC_VECTOR_DEFAULT,
  parameter int          MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
  parameter int          CNT_W           = CNT_W_DEFAULT
`ifdef EXC_REDIRECT_TIMEOUT_EN
  , parameter int        DRAIN_TIMEOUT   = 255
`endif
) (
  input logic                        clk,
  input logic                        resetn,
  exception_redirect_ctrl_if.master  bus
);

  state_t           state, state_next;
  logic [31:0]      target;
  logic [CNT_W-1:0] discard_cnt;
  logic [CNT_W-1:0] inst_cnt;
  logic [CNT_W-1:0] data_cnt;
  logic             flush_q;
  logic             accept;
  logic             discard;

  outstanding_counter #(.CNT_W(CNT_W), .MAX(MAX_OUTSTANDING)) u_inst_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (bus.inst_req_fire),
    .dec    (bus.inst_resp_fire),
    .count  (inst_cnt)
  );

  outstanding_counter #(.CNT_W(CNT_W), .MAX(MAX_OUTSTANDING)) u_data_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (bus.data_req_fire),
    .dec    (bus.data_resp_fire),
    .count  (data_cnt)
  );

`ifdef EXC_REDIRECT_TIMEOUT_EN
  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic            timeout_err_q;

  assign timeout_hit = (state == DRAIN) && (to_cnt == TO_W'(DRAIN_TIMEOUT));

  // Count cycles spent in DRAIN and register a one-cycle error on expiry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      to_cnt        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_hit;
      if (state == DRAIN && !timeout_hit) to_cnt <= to_cnt + TO_W'(1);
      else                                to_cnt <= '0;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic, commit acceptance and stale-response discard.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    discard    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.exc_valid || bus.eret_valid) begin
          accept     = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        discard = bus.inst_resp_fire && (discard_cnt != '0);
        if (discard_cnt == '0 && data_cnt == '0) state_next = REDIRECT;
`ifdef EXC_REDIRECT_TIMEOUT_EN
        if (timeout_hit) state_next = REDIRECT;
`endif
      end
      REDIRECT: begin
        if (bus.if_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the redirect target and the number of cancelled fetches to drop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      target      <= '0;
      discard_cnt <= '0;
      flush_q     <= 1'b0;
    end else begin
      flush_q <= accept;
      if (accept) begin
        target      <= bus.exc_valid ? EXC_VECTOR : bus.epc;
        discard_cnt <= CNT_W'(next_count(int'(inst_cnt), bus.inst_req_fire,
                                         bus.inst_resp_fire, MAX_OUTSTANDING));
      end else if (discard) begin
        discard_cnt <= discard_cnt - CNT_W'(1);
      end
`ifdef EXC_REDIRECT_TIMEOUT_EN
      if (timeout_hit) discard_cnt <= '0;
`endif
    end
  end

  assign bus.flush             = flush_q;
  assign bus.fetch_hold        = (state != IDLE);
  assign bus.busy              = (state != IDLE);
  assign bus.redirect_valid    = (state == REDIRECT);
  assign bus.redirect_pc       = target;
  assign bus.inst_resp_discard = discard;
  assign bus.inst_outstanding  = inst_cnt;

endmodule

// File: tb/tb_exception_redirect_ctrl.sv
// Directed, table-driven bench for exception_redirect_ctrl (default build).
module tb_exception_redirect_ctrl;

  localparam logic [7:0] I_NONE = 8'h00, I_RST  = 8'h80, I_EXC  = 8'h40,
                         I_ERET = 8'h20, I_IREQ = 8'h10, I_IRSP = 8'h08,
                         I_DREQ = 8'h04, I_DRSP = 8'h02, I_RDY  = 8'h01;
  localparam logic [4:0] O_NONE = 5'h00, O_FLUSH = 5'h10, O_HOLD = 5'h08,
                         O_RV   = 5'h04, O_DISC  = 5'h02, O_BUSY = 5'h01;
  localparam logic [4:0] O_DRN  = O_HOLD | O_BUSY;
  localparam logic [4:0] O_RED  = O_HOLD | O_BUSY | O_RV;
  localparam logic [31:0] VEC   = 32'hBFC00380;

  typedef struct {
    string       name;
    logic [7:0]  in;
    logic [31:0] epc;
    logic [4:0]  out;
    logic [2:0]  io;
    logic        chk_pc;
    logic [31:0] pc;
  } vec_t;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  int   flush_seen;
  vec_t vecs[$];

  exception_redirect_ctrl_if #(.CNT_W(3)) bus ();

  exception_redirect_ctrl #(
    .EXC_VECTOR(VEC), .MAX_OUTSTANDING(4), .CNT_W(3)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(input string n, input logic [7:0] in,
                                 input logic [31:0] epc, input logic [4:0] out,
                                 input logic [2:0] io, input logic chk_pc,
                                 input logic [31:0] pc);
    vec_t v;
    v.name = n; v.in = in; v.epc = epc; v.out = out;
    v.io = io; v.chk_pc = chk_pc; v.pc = pc;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic [7:0] in, input logic [31:0] epc_val);
    @(posedge clk);
    #1;
    resetn             = ~in[7];
    bus.exc_valid      = in[6];
    bus.eret_valid     = in[5];
    bus.inst_req_fire  = in[4];
    bus.inst_resp_fire = in[3];
    bus.data_req_fire  = in[2];
    bus.data_resp_fire = in[1];
    bus.if_ready       = in[0];
    bus.epc            = epc_val;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkVec(input vec_t v);
    checkOutput({v.name, ".flush"},   32'(bus.flush),             32'(v.out[4]));
    checkOutput({v.name, ".hold"},    32'(bus.fetch_hold),        32'(v.out[3]));
    checkOutput({v.name, ".rvalid"},  32'(bus.redirect_valid),    32'(v.out[2]));
    checkOutput({v.name, ".discard"}, 32'(bus.inst_resp_discard), 32'(v.out[1]));
    checkOutput({v.name, ".busy"},    32'(bus.busy),              32'(v.out[0]));
    checkOutput({v.name, ".inst_out"}, 32'(bus.inst_outstanding), 32'(v.io));
    if (v.chk_pc) checkOutput({v.name, ".pc"}, bus.redirect_pc, v.pc);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    flush_seen = 0;
    resetn = 1'b0;
    bus.exc_valid = 1'b0;      bus.eret_valid = 1'b0;    bus.epc = '0;
    bus.inst_req_fire = 1'b0;  bus.inst_resp_fire = 1'b0;
    bus.data_req_fire = 1'b0;  bus.data_resp_fire = 1'b0;
    bus.if_ready = 1'b0;

    // Expected outputs are sampled in the cycle the inputs are applied.
    addVec("rst",       I_RST,           0, O_NONE,         0, 1, 0);
    addVec("s1_accept", I_EXC,           0, O_NONE,         0, 0, 0);
    addVec("s1_drain",  I_NONE,          0, O_DRN|O_FLUSH,  0, 0, 0);
    addVec("s1_redir",  I_RDY,           0, O_RED,          0, 1, VEC);
    addVec("s1_idle",   I_NONE,          0, O_NONE,         0, 0, 0);
    addVec("s2_req0",   I_IREQ,          0, O_NONE,         0, 0, 0);
    addVec("s2_req1",   I_IREQ,          0, O_NONE,         1, 0, 0);
    addVec("s2_accept", I_EXC,           0, O_NONE,         2, 0, 0);
    addVec("s2_disc0",  I_IRSP,          0, O_DRN|O_FLUSH|O_DISC, 2, 0, 0);
    addVec("s2_disc1",  I_IRSP,          0, O_DRN|O_DISC,   1, 0, 0);
    addVec("s2_drain",  I_NONE,          0, O_DRN,          0, 0, 0);
    addVec("s2_redir",  I_RDY,           0, O_RED,          0, 1, VEC);
    addVec("s2_newreq", I_IREQ,          0, O_NONE,         0, 0, 0);
    addVec("s2_newrsp", I_IRSP,          0, O_NONE,         1, 0, 0);
    addVec("s2_idle",   I_NONE,          0, O_NONE,         0, 0, 0);
    addVec("s3_store",  I_DREQ,          0, O_NONE,         0, 0, 0);
    addVec("s3_eret",   I_ERET|I_IREQ,   32'h8000_1234, O_NONE, 0, 0, 0);
    addVec("s3_drain0", I_NONE,          0, O_DRN|O_FLUSH,  1, 0, 0);
    addVec("s3_disc",   I_IRSP,          0, O_DRN|O_DISC,   1, 0, 0);
    addVec("s3_wait0",  I_NONE,          0, O_DRN,          0, 0, 0);
    addVec("s3_dresp",  I_DRSP,          0, O_DRN,          0, 0, 0);
    addVec("s3_wait1",  I_NONE,          0, O_DRN,          0, 0, 0);
    addVec("s3_redir",  I_RDY,           0, O_RED,          0, 1, 32'h8000_1234);
    addVec("s3_idle",   I_NONE,          0, O_NONE,         0, 0, 0);
    addVec("s4_both",   I_EXC|I_ERET,    32'h1, O_NONE,     0, 0, 0);
    addVec("s4_drain",  I_NONE,          0, O_DRN|O_FLUSH,  0, 0, 0);
    addVec("s4_redir",  I_RDY,           0, O_RED,          0, 1, VEC);
    addVec("s4_idle",   I_NONE,          0, O_NONE,         0, 0, 0);

    applyStimulus(I_RST, 0);
    applyStimulus(I_RST, 0);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].in, vecs[i].epc);
      checkVec(vecs[i]);
    end

    // REDIRECT stalled by IF with an exception arriving mid-stall.
    $display("[TB] stall sequence");
    applyStimulus(I_EXC, 0);
    if (bus.flush) flush_seen++;
    applyStimulus(I_NONE, 0);
    if (bus.flush) flush_seen++;
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 2) ? I_EXC : I_NONE, 32'h0000_0040);
      if (bus.flush) flush_seen++;
      checkOutput($sformatf("stall%0d.rvalid", i), 32'(bus.redirect_valid), 1);
      checkOutput($sformatf("stall%0d.pc", i), bus.redirect_pc, VEC);
    end
    applyStimulus(I_RDY, 0);
    if (bus.flush) flush_seen++;
    checkOutput("stall.hs_rvalid", 32'(bus.redirect_valid), 1);
    applyStimulus(I_NONE, 0);
    if (bus.flush) flush_seen++;
    checkOutput("stall.end_busy", 32'(bus.busy), 0);
    checkOutput("stall.end_hold", 32'(bus.fetch_hold), 0);
    applyStimulus(I_NONE, 0);
    if (bus.flush) flush_seen++;
    checkOutput("stall.flush_count", 32'(flush_seen), 1);

    // Reset asserted while DRAIN waits on a data response.
    $display("[TB] reset-in-drain sequence");
    applyStimulus(I_DREQ, 0);
    applyStimulus(I_ERET | I_IREQ, 32'h8000_5678);
    applyStimulus(I_NONE, 0);
    checkOutput("rd.drain_busy", 32'(bus.busy), 1);
    checkOutput("rd.drain_io",   32'(bus.inst_outstanding), 1);
    applyStimulus(I_RST, 0);
    checkOutput("rd.still_drain", 32'(bus.busy), 1);
    applyStimulus(I_NONE, 0);
    checkVec('{name: "rd.after_rst", in: I_NONE, epc: 0, out: O_NONE,
               io: 0, chk_pc: 1, pc: 0});
    applyStimulus(I_IRSP, 0);
    checkOutput("rd.stray_io",   32'(bus.inst_outstanding), 0);
    checkOutput("rd.stray_disc", 32'(bus.inst_resp_discard), 0);
    applyStimulus(I_NONE, 0);
    checkOutput("rd.idle_busy", 32'(bus.busy), 0);
    checkOutput("rd.idle_rv",   32'(bus.redirect_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_redirect_ctrl.md
Name: exception_redirect_ctrl

Overview:
- Sequences pipeline recovery after an exception or ERET commits in MEM.
- Pulses the flush and holds fetch.
- Drains or cancels outstanding SRAM-like instruction/data bus transactions.
- Then hands IF a redirect PC (exception vector or EPC) over a valid/ready handshake.
- Sits between the CP0/exception logic in MEM and the IF stage's PC mux and bus interface.

Parameters:
- EXC_VECTOR, 32'hBFC00380, exception entry PC (BEV=1).
- MAX_OUTSTANDING, 4, maximum in-flight requests per bus.
- CNT_W, 3, outstanding counter width; must be able to hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- exc_valid  in  1  MEM commits an exception this cycle
- eret_valid  in  1  MEM commits ERET this cycle
- epc  in  32  current CP0 EPC, ERET target
- inst_req_fire  in  1  inst request accepted (req & addr_ok)
- inst_resp_fire  in  1  inst response returned (data_ok)
- data_req_fire  in  1  data request accepted
- data_resp_fire  in  1  data response returned
- if_ready  in  1  IF accepts redirect
- flush  out  1  one-cycle pulse; clears IF..MEM valid bits
- fetch_hold  out  1  IF must not issue inst requests
- redirect_valid  out  1  redirect PC offered
- redirect_pc  out  32  redirect target
- inst_resp_discard  out  1  current inst response belongs to a cancelled fetch; IF drops it
- busy  out  1  state != IDLE
- inst_outstanding  out  CNT_W  in-flight inst requests

Behaviour:
- Reset: synchronous, active-low resetn on clk. All outputs 0, redirect_pc 0, state IDLE, all counters 0. Reset mid-operation aborts to IDLE immediately.
- Outstanding counters (inst, data), each cycle:
  - cnt += req_fire - resp_fire.
  - req_fire at cnt==MAX_OUTSTANDING: protocol error; counter holds.
  - resp_fire at cnt==0 with no req: ignored.
  - Simultaneous req and resp: counter unchanged.
- States IDLE, DRAIN, REDIRECT.
- IDLE, on exc_valid|eret_valid (accept cycle):
  - target <= exc_valid ? EXC_VECTOR : epc. Exception wins over a simultaneous ERET.
  - discard_cnt <= next-cycle inst_outstanding value, i.e. including this cycle's req/resp fires.
  - Next cycle: flush=1 for exactly one cycle; fetch_hold=1; state DRAIN.
- DRAIN:
  - fetch_hold=1.
  - inst_resp_discard = inst_resp_fire & (discard_cnt!=0), combinational; discard_cnt decrements on each discard.
  - Leave when discard_cnt==0 and data outstanding==0 (stores complete; load data dropped by the flushed pipeline). Leave on the evaluating cycle; next state REDIRECT.
  - If both conditions already hold on DRAIN entry, DRAIN lasts exactly one cycle.
- REDIRECT:
  - redirect_valid=1, redirect_pc=target; fetch_hold stays 1.
  - On redirect_valid & if_ready: next cycle IDLE, redirect_valid=0, fetch_hold=0.
- exc_valid/eret_valid outside IDLE: ignored; the pipeline is already flushed.
- Latency: accept -> flush is 1 cycle; accept -> redirect_valid is at least 2 cycles (minimum path accept, DRAIN, REDIRECT).
- Redirect_pc holds stable while redirect_valid=1 and if_ready=0.

Optional Feature:
- Macro EXC_REDIRECT_TIMEOUT_EN.
- Enabled:
  - Adds parameter DRAIN_TIMEOUT (default 255) and output timeout_err (1 bit, reset 0).
  - A counter runs in DRAIN. On reaching DRAIN_TIMEOUT, force transition to REDIRECT, clear discard_cnt, and pulse timeout_err for one cycle.
- Disabled: no counter and no port; DRAIN waits indefinitely.

Decomposition:
- Shared CP0 package holds: state encoding constants (IDLE=2'd0, DRAIN=2'd1, REDIRECT=2'd2) and the EXC_VECTOR default.
- One sub-module, outstanding_counter: saturating up/down counter with parameter CNT_W and MAX. Instantiated twice (inst, data).

Test Plan:
- Idle, counters 0, exc_valid 1 cycle -> flush pulse next cycle; DRAIN 1 cycle; redirect_valid with redirect_pc=32'hBFC00380; if_ready=1 -> IDLE; busy=0.
- 2 inst requests in flight, exc_valid -> fetch_hold=1; first 2 inst_resp_fire have inst_resp_discard=1; redirect_valid after 2nd response; third response (new fetch) not discarded.
- eret_valid, epc=32'h8000_1234, 1 data store outstanding -> redirect waits for data_resp_fire; redirect_pc=32'h8000_1234.
- exc_valid and eret_valid same cycle, epc=32'h1 -> redirect_pc=32'hBFC00380.
- REDIRECT with if_ready low 5 cycles, then exc_valid pulse -> redirect_pc stable; exc ignored; single flush total.
- resetn low during DRAIN -> next cycle all outputs 0, state IDLE, inst_outstanding=0.
